// File: rtl/iob_soc_opencryptolinux_boot_mgr_pkg.sv
// -----------------------------------------------------------------------------
// iob_soc_opencryptolinux_boot_mgr_pkg
// Shared definitions for the boot/reset manager: register word offsets
// (address bits [3:2]), per-channel FSM state encoding and CFG field layout.
// -----------------------------------------------------------------------------
package iob_soc_opencryptolinux_boot_mgr_pkg;

    // Register word offsets, decoded from address bits [3:2]
    localparam logic [1:0] ADDR_BOOT    = 2'd0;
    localparam logic [1:0] ADDR_RST_REQ = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CFG     = 2'd3;

    // CFG register field positions
    localparam int CFG_NCPUS_LSB = 0;
    localparam int CFG_NCPUS_W   = 8;
    localparam int CFG_DUR_LSB   = 8;
    localparam int CFG_DUR_W     = 24;

    // Per-channel sequencing states
    typedef enum logic [1:0] {
        CH_IDLE  = 2'b00,
        CH_DELAY = 2'b01,
        CH_PULSE = 2'b10
    } chan_state_e;

    // Build the read-only CFG word; DURATION is truncated to its field width
    function automatic logic [31:0] cfg_word(input int n_cpus, input int duration);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[CFG_NCPUS_LSB +: CFG_NCPUS_W] = CFG_NCPUS_W'(n_cpus);
        w[CFG_DUR_LSB +: CFG_DUR_W]     = CFG_DUR_W'(duration);
        return w;
    endfunction

    // Larger of two integers, used to size the shared channel counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iob_soc_opencryptolinux_boot_mgr_chan.sv
// -----------------------------------------------------------------------------
// iob_soc_opencryptolinux_boot_mgr_chan
// One boot/reset channel: IDLE -> DELAY (START_DELAY cycles) -> PULSE
// (DURATION cycles) -> IDLE. The CPU reset is high in DELAY and PULSE.
// The boot mode is sampled from the staged BOOT bit on entry to PULSE.
//
// Ports:
//   clk_i         clock (rising edge)
//   rst_i         synchronous active-high reset (restarts at DELAY)
//   cke_i         clock enable; state frozen when low
//   req_i         reset request (one-cycle strobe from RST_REQ write)
//   boot_stage_i  staged boot-mode bit from the BOOT register
//   busy_o        channel not IDLE
//   cpu_reset_o   CPU reset, active-high
//   boot_o        boot mode latched at DELAY->PULSE
// -----------------------------------------------------------------------------
module iob_soc_opencryptolinux_boot_mgr_chan
    import iob_soc_opencryptolinux_boot_mgr_pkg::*;
#(
    parameter int   START_DELAY  = 4,
    parameter int   DURATION     = 100,
    parameter int   CNT_W        = 7,
    parameter logic BOOT_RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cke_i,
    input  logic req_i,
    input  logic boot_stage_i,
    output logic busy_o,
    output logic cpu_reset_o,
    output logic boot_o
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DURATION - 1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boot_q, boot_d;
    logic             rst_out_q, rst_out_d;

    // Next-state, counter and boot-latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        case (state_q)
            CH_IDLE: begin
                if (req_i) begin
                    state_d = CH_DELAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = '0;
                end
            end
            CH_DELAY: begin
                // Requests are ignored while waiting for the pulse to start
                if (cnt_q == DLY_LAST) begin
                    state_d = CH_PULSE;
                    cnt_d   = '0;
                    boot_d  = boot_stage_i;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            CH_PULSE: begin
                // A new request restarts the pulse length (extends the pulse)
                if (req_i) begin
                    cnt_d   = '0;
                end else if (cnt_q == DUR_LAST) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase
        rst_out_d = (state_d != CH_IDLE);
    end

    // State register; reset starts a fresh power-on sequence from DELAY
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CH_DELAY;
            cnt_q     <= '0;
            boot_q    <= BOOT_RST_VAL;
            rst_out_q <= 1'b1;
        end else if (cke_i) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            boot_q    <= boot_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign busy_o      = rst_out_q;
    assign cpu_reset_o = rst_out_q;
    assign boot_o      = boot_q;

endmodule

// File: rtl/iob_soc_opencryptolinux_boot_mgr.sv
// -----------------------------------------------------------------------------
// iob_soc_opencryptolinux_boot_mgr
// IOb-slave boot/reset manager for N_CPUS CPUs. Each CPU gets an independent
// reset sequencer and a boot-mode bit.
//
// Register map (word offset from address bits [3:2]):
//   0x0 BOOT    RW  staged boot mode, bits [N_CPUS-1:0]
//   0x4 RST_REQ W   write 1 to bit i to start/extend channel i reset
//   0x8 STATUS  R   busy bits (channel not idle)
//   0xC CFG     R   [7:0]=N_CPUS, [31:8]=DURATION
//
// Ports:
//   clk_i, rst_i, cke_i             clock, sync active-high reset, clock enable
//   iob_valid_i/addr_i/wdata_i/wstrb_i  IOb request (wstrb==0 means read)
//   iob_rvalid_o/rdata_o            registered read response (1-cycle latency)
//   iob_ready_o                     always 1
//   boot_o                          per-CPU boot mode
//   cpu_reset_o                     per-CPU reset, active-high
// -----------------------------------------------------------------------------
module iob_soc_opencryptolinux_boot_mgr
    import iob_soc_opencryptolinux_boot_mgr_pkg::*;
#(
    parameter int                ADDR_W       = 4,
    parameter int                DATA_W       = 32,
    parameter int                N_CPUS       = 2,
    parameter int                START_DELAY  = 4,
    parameter int                DURATION     = 100,
    parameter logic [N_CPUS-1:0] BOOT_RST_VAL = {N_CPUS{1'b1}}
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [N_CPUS-1:0]   boot_o,
    output logic [N_CPUS-1:0]   cpu_reset_o
);

    localparam int CNT_W = $clog2(max2(START_DELAY, DURATION) + 1);

    logic              wr_s;
    logic              rd_s;
    logic [1:0]        addr_word_s;
    logic [N_CPUS-1:0] rst_req_s;
    logic [N_CPUS-1:0] busy_s;
    logic [N_CPUS-1:0] boot_q, boot_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Only address bits [3:2] and the low N_CPUS data bits carry meaning
    logic unused_addr_s;
    logic unused_wdata_s;
    assign unused_addr_s  = ^iob_addr_i;
    assign unused_wdata_s = ^iob_wdata_i;

    assign iob_ready_o = 1'b1;
    assign wr_s        = iob_valid_i & (|iob_wstrb_i);
    assign rd_s        = iob_valid_i & ~(|iob_wstrb_i);
    assign addr_word_s = iob_addr_i[3:2];

    // Decode RST_REQ writes into per-channel request strobes
    always_comb begin
        rst_req_s = '0;
        if (wr_s && (addr_word_s == ADDR_RST_REQ)) begin
            rst_req_s = iob_wdata_i[N_CPUS-1:0];
        end else begin
            rst_req_s = '0;
        end
    end

    // Staged BOOT register next value
    always_comb begin
        boot_d = boot_q;
        if (wr_s && (addr_word_s == ADDR_BOOT)) begin
            boot_d = iob_wdata_i[N_CPUS-1:0];
        end else begin
            boot_d = boot_q;
        end
    end

    // Read data mux; response data is forced to zero when no read is accepted
    always_comb begin
        rvalid_d = rd_s;
        rdata_d  = '0;
        if (rd_s) begin
            case (addr_word_s)
                ADDR_BOOT:   rdata_d[N_CPUS-1:0] = boot_q;
                ADDR_STATUS: rdata_d[N_CPUS-1:0] = busy_s;
                ADDR_CFG:    rdata_d = cfg_word(N_CPUS, DURATION);
                default:     rdata_d = '0;
            endcase
        end else begin
            rdata_d = '0;
        end
    end

    // BOOT register and registered read response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_q   <= BOOT_RST_VAL;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            boot_q   <= boot_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;

    genvar g;
    generate
        for (g = 0; g < N_CPUS; g = g + 1) begin : g_chan
            iob_soc_opencryptolinux_boot_mgr_chan #(
                .START_DELAY  (START_DELAY),
                .DURATION     (DURATION),
                .CNT_W        (CNT_W),
                .BOOT_RST_VAL (BOOT_RST_VAL[g])
            ) u_chan (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .cke_i        (cke_i),
                .req_i        (rst_req_s[g]),
                .boot_stage_i (boot_q[g]),
                .busy_o       (busy_s[g]),
                .cpu_reset_o  (cpu_reset_o[g]),
                .boot_o       (boot_o[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_iob_soc_opencryptolinux_boot_mgr.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for iob_soc_opencryptolinux_boot_mgr
// (defaults: N_CPUS=2, START_DELAY=4, DURATION=100). Inputs are driven and
// outputs sampled on the falling edge; cyc counts falling edges.
// -----------------------------------------------------------------------------
module tb_iob_soc_opencryptolinux_boot_mgr;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cke_i;
    logic        iob_valid_i;
    logic [3:0]  iob_addr_i;
    logic [31:0] iob_wdata_i;
    logic [3:0]  iob_wstrb_i;
    logic        iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic        iob_ready_o;
    logic [1:0]  boot_o;
    logic [1:0]  cpu_reset_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    iob_soc_opencryptolinux_boot_mgr dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cke_i        (cke_i),
        .iob_valid_i  (iob_valid_i),
        .iob_addr_i   (iob_addr_i),
        .iob_wdata_i  (iob_wdata_i),
        .iob_wstrb_i  (iob_wstrb_i),
        .iob_rvalid_o (iob_rvalid_o),
        .iob_rdata_o  (iob_rdata_o),
        .iob_ready_o  (iob_ready_o),
        .boot_o       (boot_o),
        .cpu_reset_o  (cpu_reset_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        iob_valid_i = 1'b1;
        iob_addr_i  = a;
        iob_wdata_i = d;
        iob_wstrb_i = 4'hF;
        step();
        iob_valid_i = 1'b0;
        iob_wstrb_i = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        iob_valid_i = 1'b1;
        iob_addr_i  = a;
        iob_wstrb_i = 4'h0;
        step();
        iob_valid_i = 1'b0;
        check({tag, "_rvalid"}, {31'd0, iob_rvalid_o}, 32'd1);
        check({tag, "_rdata"}, iob_rdata_o, exp);
    endtask

    // Count consecutive samples with cpu_reset_o[ch] high, bounded
    task automatic measure_high(input int ch, output int n);
        n = 0;
        while (cpu_reset_o[ch] === 1'b1 && n < 400) begin
            n++;
            step();
        end
    endtask

    initial begin
        int w0;
        int n;
        rst_i       = 1'b1;
        cke_i       = 1'b1;
        iob_valid_i = 1'b0;
        iob_addr_i  = 4'h0;
        iob_wdata_i = 32'h0;
        iob_wstrb_i = 4'h0;
        step();
        step();
        step();

        // Reset state
        check("rst_cpu_reset", {30'd0, cpu_reset_o}, 32'h3);
        check("rst_boot", {30'd0, boot_o}, 32'h3);
        check("rst_rvalid", {31'd0, iob_rvalid_o}, 32'h0);
        check("rst_rdata", iob_rdata_o, 32'h0);
        check("ready", {31'd0, iob_ready_o}, 32'h1);

        // Power-on sequence: 104 cycles high after release
        rst_i = 1'b0;
        measure_high(0, n);
        check("por_len", n, 32'd104);
        check("por_both_low", {30'd0, cpu_reset_o}, 32'h0);
        check("por_boot", {30'd0, boot_o}, 32'h3);
        step();

        // BOOT=1, then reset channel 1 only
        wr(4'h0, 32'h1);
        w0 = cyc;
        wr(4'h4, 32'h2);
        check("ch1_rise", {30'd0, cpu_reset_o}, 32'h2);
        check("ch1_boot_early", {30'd0, boot_o}, 32'h3);
        goto(w0 + 4);
        check("ch1_boot_c4", {30'd0, boot_o}, 32'h3);
        goto(w0 + 5);
        check("ch1_boot_c5", {30'd0, boot_o}, 32'h1);
        measure_high(1, n);
        check("ch1_pulse_len", n + 4, 32'd104);
        check("ch1_end", {30'd0, cpu_reset_o}, 32'h0);
        check("ch1_end_boot", {30'd0, boot_o}, 32'h1);
        step();

        // Channel 0: repeat in DELAY ignored, register reads, repeat in PULSE
        w0 = cyc;
        wr(4'h4, 32'h1);
        check("ch0_rise", {30'd0, cpu_reset_o}, 32'h1);
        wr(4'h4, 32'h1);
        goto(w0 + 10);
        rd(4'h8, 32'h1, "status");
        step();
        check("idle_rvalid", {31'd0, iob_rvalid_o}, 32'h0);
        check("idle_rdata", iob_rdata_o, 32'h0);
        rd(4'hC, 32'h6402, "cfg");
        rd(4'h4, 32'h0, "rstreq_rd");
        rd(4'h0, 32'h1, "boot_rd");
        goto(w0 + 54);
        wr(4'h4, 32'h1);
        measure_high(0, n);
        check("ch0_extended_len", n + 54, 32'd154);
        check("ch0_ext_boot", {30'd0, boot_o}, 32'h1);

        // Write to read-only CFG is ignored
        wr(4'hC, 32'hFFFF_FFFF);
        rd(4'hC, 32'h6402, "cfg_ro");

        // Clock enable low for 20 cycles mid-pulse
        step();
        w0 = cyc;
        wr(4'h4, 32'h1);
        goto(w0 + 30);
        cke_i = 1'b0;
        goto(w0 + 40);
        check("cke_hold", {30'd0, cpu_reset_o}, 32'h1);
        goto(w0 + 50);
        cke_i = 1'b1;
        measure_high(0, n);
        check("cke_len", n + 49, 32'd124);

        // Simultaneous requests on both channels
        step();
        wr(4'h4, 32'h3);
        check("both_rise", {30'd0, cpu_reset_o}, 32'h3);
        rd(4'h8, 32'h3, "status_both");
        measure_high(0, n);
        check("both_len", n + 1, 32'd104);
        check("both_low", {30'd0, cpu_reset_o}, 32'h0);

        // Reset mid-pulse with BOOT=0: restart full sequence, boot back to ones
        wr(4'h0, 32'h0);
        w0 = cyc;
        wr(4'h4, 32'h1);
        goto(w0 + 34);
        check("pre_rst_boot", {30'd0, boot_o}, 32'h0);
        rst_i = 1'b1;
        step();
        check("mid_rst_cpu_reset", {30'd0, cpu_reset_o}, 32'h3);
        check("mid_rst_boot", {30'd0, boot_o}, 32'h3);
        rst_i = 1'b0;
        measure_high(0, n);
        check("mid_rst_len", n, 32'd104);
        check("mid_rst_boot_after", {30'd0, boot_o}, 32'h3);
        rd(4'h0, 32'h3, "boot_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
